pipeline_retire_monitor: RTL and testbench
==========================================

# pipeline_retire_monitor

- Synthesizable observer at the write-back end of the pipelined processor.
- Consumes the retire stream and counts cycles and retired instructions.
- Buffers register-write commits in a small FIFO that a bench or debug reader drains.
- Declares the run finished on a halt instruction or a cycle limit, then asserts a sticky done once the trace is fully drained.

## Interface
Parameters:
- CYCLE_LIMIT, 100, run cycles before timeout (≥1)
- FIFO_DEPTH, 8, trace entries (power of 2, ≥2)
- HALT_INSTR, 32'h00000073, instruction word that ends the run (ecall)

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- i_Clk  input  1  clock
- i_Reset  input  1  asynchronous, active-high reset
- i_Retire_Valid  input  1  an instruction retires this cycle
- i_Retire_PC  input  32  PC of retiring instruction
- i_Retire_Instr  input  32  instruction word
- i_Rd_Write  input  1  retiring instruction writes a register
- i_Rd_Addr  input  5  destination register
- i_Rd_Data  input  32  write-back value
- i_Trace_Ready  input  1  reader accepts head entry
- o_Trace_Valid  output  1  FIFO non-empty
- o_Trace_PC  output  32  head entry PC
- o_Trace_Rd_Addr  output  5  head entry rd
- o_Trace_Rd_Data  output  32  head entry data
- o_Dropped  output  8  saturating count of commits lost to a full FIFO
- o_Retired_Count  output  32  instructions retired in RUN
- o_Cycle_Count  output  32  cycles spent in RUN
- o_Done  output  1  run finished and trace drained (sticky)
- o_Done_Cause  output  2  00 running, 01 halt, 10 timeout

## Operation
- States RUN, DRAIN, DONE. Reset enters RUN.
- On reset, all counters are 0, the FIFO is empty, o_Trace_Valid=0, o_Done=0 and o_Done_Cause=00. Trace data outputs are don't-care while o_Trace_Valid=0.
- RUN:
  - o_Cycle_Count increments every cycle.
  - o_Retired_Count increments on each i_Retire_Valid.
  - A commit is an i_Retire_Valid cycle with i_Rd_Write=1. A commit pushes {PC, rd, data}.
  - Push is accepted when the FIFO is not full, or when it is full and a pop occurs in the same cycle. Otherwise o_Dropped increments, saturating at 255.
- RUN→DRAIN on i_Retire_Valid with i_Retire_Instr==HALT_INSTR, with cause 01. The halt instruction is counted and is pushed if it commits.
- RUN→DRAIN when o_Cycle_Count increments to CYCLE_LIMIT, with cause 10.
- If halt and limit occur on the same edge, halt wins (cause 01).
- o_Done_Cause is registered together with the RUN→DRAIN transition.
- DRAIN:
  - Counters frozen; retire inputs ignored; pops continue.
  - DRAIN→DONE on an edge where the FIFO is empty.
- DONE: o_Done=1 and all state is held until reset; pops of a (necessarily empty) FIFO have no effect.
- FIFO is first-word-fall-through. Pop = o_Trace_Valid && i_Trace_Ready. The head entry updates on the edge after a pop.
- Occupancy counter is log2(FIFO_DEPTH)+1 bits wide; read and write pointers wrap modulo FIFO_DEPTH.

## Timing
- Push→o_Trace_Valid: 1 cycle, visible after the edge that captures the entry.
- Halt retiring in cycle n with the FIFO empty: DRAIN after edge n, DONE and o_Done=1 after edge n+1.
- Timeout with CYCLE_LIMIT=100 and the FIFO empty: o_Cycle_Count reaches 100 at edge 100 (DRAIN), o_Done=1 after edge 101.
- Reset asserted mid-run or mid-drain: outputs return to reset values immediately (asynchronous). The first counted cycle is the first edge with i_Reset low.

## Configuration
- Macro RETIRE_MONITOR_X0_FILTER_EN.
- Defined: commits with i_Rd_Addr==0 are not pushed and never count as drops.
- Undefined: x0 commits are pushed like any other commit.
- Retired and cycle counting are identical in both builds.

## Test plan
- Reset release, no retires, CYCLE_LIMIT=100, i_Trace_Ready=1 → o_Cycle_Count=100, o_Done=1 one edge later, o_Done_Cause=10, o_Retired_Count=0.
- Three commits (x1=5, x2=7, x3=12), then HALT_INSTR, i_Trace_Ready=0 → three entries held, o_Done=0 in DRAIN. Raise ready → entries pop in order, o_Done=1 the edge after empty, cause 01, o_Retired_Count=4.
- FIFO_DEPTH=8, ready=0, 10 commits → 8 entries buffered, o_Dropped=2. Commit with simultaneous pop while full → accepted, o_Dropped stays 2.
- HALT_INSTR retiring on the same edge the cycle count hits CYCLE_LIMIT → o_Done_Cause=01.
- Commit to x0 with data 32'hDEAD → with RETIRE_MONITOR_X0_FILTER_EN, o_Trace_Valid stays 0. Without it, an entry with rd=0 and data DEAD appears.
- i_Reset pulsed during DRAIN with 4 entries queued → o_Trace_Valid=0, all counts 0, state RUN, o_Done=0 immediately.

Source files
------------

// File: rtl/pipeline_retire_monitor.sv
// Write-back observer: counts cycles/retires, buffers register commits in a FWFT trace FIFO,
// and raises a sticky done once the run ends and the trace drains. Optional build macro: RETIRE_MONITOR_X0_FILTER_EN.
module pipeline_retire_monitor #(
    parameter int          CYCLE_LIMIT = 100,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [31:0] HALT_INSTR  = 32'h00000073
) (
    input  logic        i_Clk,
    input  logic        i_Reset,
    input  logic        i_Retire_Valid,
    input  logic [31:0] i_Retire_PC,
    input  logic [31:0] i_Retire_Instr,
    input  logic        i_Rd_Write,
    input  logic [4:0]  i_Rd_Addr,
    input  logic [31:0] i_Rd_Data,
    input  logic        i_Trace_Ready,
    output logic        o_Trace_Valid,
    output logic [31:0] o_Trace_PC,
    output logic [4:0]  o_Trace_Rd_Addr,
    output logic [31:0] o_Trace_Rd_Data,
    output logic [7:0]  o_Dropped,
    output logic [31:0] o_Retired_Count,
    output logic [31:0] o_Cycle_Count,
    output logic        o_Done,
    output logic [1:0]  o_Done_Cause
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_t;

    state_t        state_q, state_d;
    logic [31:0]   cycle_q, cycle_d;
    logic [31:0]   retired_q, retired_d;
    logic [7:0]    dropped_q, dropped_d;
    logic [1:0]    cause_q, cause_d;
    logic          done_q, done_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;

    logic [31:0]   trace_pc_q   [FIFO_DEPTH];
    logic [4:0]    trace_rd_q   [FIFO_DEPTH];
    logic [31:0]   trace_data_q [FIFO_DEPTH];

    logic          is_run, fifo_empty, fifo_full, pop, commit, push, halt, limit_hit, rd_ok;
    logic [31:0]   cycle_inc;

`ifdef RETIRE_MONITOR_X0_FILTER_EN
    assign rd_ok = (i_Rd_Addr != 5'd0);
`else
    assign rd_ok = 1'b1;
`endif

    assign is_run     = (state_q == ST_RUN);
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == (AW+1)'(FIFO_DEPTH));
    assign pop        = !fifo_empty && i_Trace_Ready;
    assign commit     = is_run && i_Retire_Valid && i_Rd_Write && rd_ok;
    // A full FIFO still accepts when the head leaves on the same edge.
    assign push       = commit && (!fifo_full || pop);
    assign halt       = is_run && i_Retire_Valid && (i_Retire_Instr == HALT_INSTR);
    assign cycle_inc  = cycle_q + 32'd1;
    assign limit_hit  = is_run && (cycle_inc == 32'(CYCLE_LIMIT));

    always_comb begin
        state_d   = state_q;
        cycle_d   = cycle_q;
        retired_d = retired_q;
        dropped_d = dropped_q;
        cause_d   = cause_q;
        done_d    = done_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;

        case (state_q)
            ST_RUN: begin
                cycle_d = cycle_inc;
                if (i_Retire_Valid) retired_d = retired_q + 32'd1;
                if (commit && !push && (dropped_q != 8'hFF)) dropped_d = dropped_q + 8'd1;
                if (halt) begin
                    state_d = ST_DRAIN;
                    cause_d = 2'b01;
                end else if (limit_hit) begin
                    state_d = ST_DRAIN;
                    cause_d = 2'b10;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            ST_DONE: ;
            default: state_d = ST_RUN;
        endcase

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_q   <= ST_RUN;
            cycle_q   <= '0;
            retired_q <= '0;
            dropped_q <= '0;
            cause_q   <= '0;
            done_q    <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            cycle_q   <= cycle_d;
            retired_q <= retired_d;
            dropped_q <= dropped_d;
            cause_q   <= cause_d;
            done_q    <= done_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible while the occupancy is non-zero.
    always_ff @(posedge i_Clk) begin
        if (push) begin
            trace_pc_q[wr_ptr_q]   <= i_Retire_PC;
            trace_rd_q[wr_ptr_q]   <= i_Rd_Addr;
            trace_data_q[wr_ptr_q] <= i_Rd_Data;
        end
    end

    assign o_Trace_Valid   = !fifo_empty;
    assign o_Trace_PC      = trace_pc_q[rd_ptr_q];
    assign o_Trace_Rd_Addr = trace_rd_q[rd_ptr_q];
    assign o_Trace_Rd_Data = trace_data_q[rd_ptr_q];
    assign o_Dropped       = dropped_q;
    assign o_Retired_Count = retired_q;
    assign o_Cycle_Count   = cycle_q;
    assign o_Done          = done_q;
    assign o_Done_Cause    = cause_q;

endmodule

// File: tb/tb_pipeline_retire_monitor.sv
// Self-checking bench for pipeline_retire_monitor: vector table for the halt/drain run,
// hand-written sequences for timeout, overflow, halt/limit tie, x0 commits and mid-drain reset.
module tb_pipeline_retire_monitor;

    localparam logic [31:0] HALT = 32'h00000073;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        r_valid = 1'b0;
    logic [31:0] r_pc = '0;
    logic [31:0] r_instr = '0;
    logic        r_wr = 1'b0;
    logic [4:0]  r_rd = '0;
    logic [31:0] r_data = '0;
    logic        t_ready = 1'b0;
    logic        t_valid;
    logic [31:0] t_pc;
    logic [4:0]  t_rd;
    logic [31:0] t_data;
    logic [7:0]  dropped;
    logic [31:0] retired, cycles;
    logic        done;
    logic [1:0]  cause;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] data;
    } entry_t;

    entry_t sbq[$];

    typedef struct {
        logic        vld;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        wr;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        rdy;
        logic        push;
        logic        e_valid;
        logic [31:0] e_ret;
        logic [31:0] e_cyc;
        logic        e_done;
        logic [1:0]  e_cause;
    } vec_t;

    vec_t tbl[10];

    pipeline_retire_monitor #(
        .CYCLE_LIMIT(100),
        .FIFO_DEPTH(8),
        .HALT_INSTR(HALT)
    ) dut (
        .i_Clk(clk),
        .i_Reset(rst),
        .i_Retire_Valid(r_valid),
        .i_Retire_PC(r_pc),
        .i_Retire_Instr(r_instr),
        .i_Rd_Write(r_wr),
        .i_Rd_Addr(r_rd),
        .i_Rd_Data(r_data),
        .i_Trace_Ready(t_ready),
        .o_Trace_Valid(t_valid),
        .o_Trace_PC(t_pc),
        .o_Trace_Rd_Addr(t_rd),
        .o_Trace_Rd_Data(t_data),
        .o_Dropped(dropped),
        .o_Retired_Count(retired),
        .o_Cycle_Count(cycles),
        .o_Done(done),
        .o_Done_Cause(cause)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every accepted pop must match the oldest expected commit.
    always @(negedge clk) begin
        if (!rst && t_valid && t_ready) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL trace_pop: got pc %0h with no expected entry", t_pc);
            end else begin
                entry_t e;
                e = sbq.pop_front();
                check("trace_pc", t_pc, e.pc);
                check("trace_rd", {27'd0, t_rd}, {27'd0, e.rd});
                check("trace_data", t_data, e.data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vld, input logic [31:0] pc, input logic [31:0] instr,
                         input logic wr, input logic [4:0] rd, input logic [31:0] data,
                         input logic rdy);
        r_valid = vld;
        r_pc    = pc;
        r_instr = instr;
        r_wr    = wr;
        r_rd    = rd;
        r_data  = data;
        t_ready = rdy;
    endtask

    task automatic idle(input logic rdy);
        drive(1'b0, '0, '0, 1'b0, '0, '0, rdy);
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] data);
        entry_t e;
        e.pc = pc;
        e.rd = rd;
        e.data = data;
        sbq.push_back(e);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"}, {31'd0, t_valid}, 32'd0);
        check({tag, "_retired"}, retired, 32'd0);
        check({tag, "_cycles"}, cycles, 32'd0);
        check({tag, "_dropped"}, {24'd0, dropped}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_cause"}, {30'd0, cause}, 32'd0);
    endtask

    // Leaves reset deasserted between edges, so the next posedge is counted cycle 1.
    task automatic do_reset();
        rst = 1'b1;
        idle(1'b0);
        sbq.delete();
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst = 1'b0;
    endtask

    function automatic vec_t mk(input logic vld, input logic [31:0] pc, input logic [31:0] instr,
                                input logic wr, input logic [4:0] rd, input logic [31:0] data,
                                input logic rdy, input logic push, input logic e_valid,
                                input logic [31:0] e_ret, input logic [31:0] e_cyc,
                                input logic e_done, input logic [1:0] e_cause);
        vec_t v;
        v.vld = vld; v.pc = pc; v.instr = instr; v.wr = wr; v.rd = rd; v.data = data;
        v.rdy = rdy; v.push = push; v.e_valid = e_valid; v.e_ret = e_ret; v.e_cyc = e_cyc;
        v.e_done = e_done; v.e_cause = e_cause;
        return v;
    endfunction

    initial begin
        int waited;

        //        vld pc          instr         wr rd  data    rdy push vld ret cyc done cause
        tbl[0] = mk(1, 32'h100, 32'h00500093, 1, 1, 32'd5,  0,  1,   1,  1,  1,  0,  2'b00);
        tbl[1] = mk(1, 32'h104, 32'h00700113, 1, 2, 32'd7,  0,  1,   1,  2,  2,  0,  2'b00);
        tbl[2] = mk(1, 32'h108, 32'h00c00193, 1, 3, 32'd12, 0,  1,   1,  3,  3,  0,  2'b00);
        tbl[3] = mk(1, 32'h10c, HALT,         0, 0, 32'd0,  0,  0,   1,  4,  4,  0,  2'b01);
        tbl[4] = mk(1, 32'h110, 32'h06300293, 1, 5, 32'd99, 0,  0,   1,  4,  4,  0,  2'b01);
        tbl[5] = mk(0, 32'h0,   32'h0,        0, 0, 32'd0,  1,  0,   1,  4,  4,  0,  2'b01);
        tbl[6] = mk(0, 32'h0,   32'h0,        0, 0, 32'd0,  1,  0,   1,  4,  4,  0,  2'b01);
        tbl[7] = mk(0, 32'h0,   32'h0,        0, 0, 32'd0,  1,  0,   0,  4,  4,  0,  2'b01);
        tbl[8] = mk(0, 32'h0,   32'h0,        0, 0, 32'd0,  1,  0,   0,  4,  4,  1,  2'b01);
        tbl[9] = mk(1, 32'h200, HALT,         1, 7, 32'd1,  1,  0,   0,  4,  4,  1,  2'b01);

        // Halt run: held entries in DRAIN, ordered drain, done the edge after empty.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].vld, tbl[i].pc, tbl[i].instr, tbl[i].wr, tbl[i].rd, tbl[i].data, tbl[i].rdy);
            if (tbl[i].push) push_exp(tbl[i].pc, tbl[i].rd, tbl[i].data);
            step();
            check($sformatf("v%0d_valid", i), {31'd0, t_valid}, {31'd0, tbl[i].e_valid});
            check($sformatf("v%0d_retired", i), retired, tbl[i].e_ret);
            check($sformatf("v%0d_cycles", i), cycles, tbl[i].e_cyc);
            check($sformatf("v%0d_done", i), {31'd0, done}, {31'd0, tbl[i].e_done});
            check($sformatf("v%0d_cause", i), {30'd0, cause}, {30'd0, tbl[i].e_cause});
        end
        check("halt_sb_empty", sbq.size(), 32'd0);

        // Timeout with no retires.
        do_reset();
        idle(1'b1);
        repeat (99) step();
        check("to_cyc99", cycles, 32'd99);
        check("to_cause99", {30'd0, cause}, 32'd0);
        step();
        check("to_cyc100", cycles, 32'd100);
        check("to_cause100", {30'd0, cause}, 32'd2);
        check("to_done100", {31'd0, done}, 32'd0);
        step();
        check("to_done101", {31'd0, done}, 32'd1);
        check("to_cyc101", cycles, 32'd100);
        check("to_retired", retired, 32'd0);

        // Halt on the same edge the cycle limit is reached.
        do_reset();
        idle(1'b1);
        repeat (99) step();
        drive(1'b1, 32'h400, HALT, 1'b0, '0, '0, 1'b1);
        step();
        idle(1'b1);
        check("tie_cycles", cycles, 32'd100);
        check("tie_cause", {30'd0, cause}, 32'd1);
        check("tie_retired", retired, 32'd1);

        // Overflow: 10 commits into 8 slots, then a commit with a simultaneous pop while full.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h200 + 32'(i * 4), 32'h0, 1'b1, 5'(i + 1), 32'hA0 + 32'(i), 1'b0);
            if (i < 8) push_exp(32'h200 + 32'(i * 4), 5'(i + 1), 32'hA0 + 32'(i));
            step();
        end
        check("ovf_valid", {31'd0, t_valid}, 32'd1);
        check("ovf_dropped", {24'd0, dropped}, 32'd2);
        check("ovf_retired", retired, 32'd10);
        drive(1'b1, 32'h300, 32'h0, 1'b1, 5'd9, 32'hBEEF, 1'b1);
        push_exp(32'h300, 5'd9, 32'hBEEF);
        step();
        check("ovf_popfull_dropped", {24'd0, dropped}, 32'd2);
        check("ovf_popfull_valid", {31'd0, t_valid}, 32'd1);
        drive(1'b1, 32'h304, HALT, 1'b0, '0, '0, 1'b1);
        step();
        idle(1'b1);
        check("ovf_cause", {30'd0, cause}, 32'd1);
        waited = 0;
        while (!done && waited < 40) begin
            step();
            waited++;
        end
        check("ovf_done", {31'd0, done}, 32'd1);
        check("ovf_sb_empty", sbq.size(), 32'd0);
        check("ovf_retired_final", retired, 32'd12);

        // x0 commit.
        do_reset();
        drive(1'b1, 32'h500, 32'h0, 1'b1, 5'd0, 32'hDEAD, 1'b0);
`ifdef RETIRE_MONITOR_X0_FILTER_EN
        step();
        idle(1'b0);
        check("x0_valid", {31'd0, t_valid}, 32'd0);
        check("x0_dropped", {24'd0, dropped}, 32'd0);
`else
        push_exp(32'h500, 5'd0, 32'hDEAD);
        step();
        check("x0_valid", {31'd0, t_valid}, 32'd1);
        idle(1'b1);
        step();
        check("x0_drained", {31'd0, t_valid}, 32'd0);
        check("x0_sb_empty", sbq.size(), 32'd0);
`endif
        check("x0_retired", retired, 32'd1);

        // Asynchronous reset during DRAIN with four entries queued.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h600 + 32'(i * 4), 32'h0, 1'b1, 5'(i + 10), 32'h50 + 32'(i), 1'b0);
            step();
        end
        drive(1'b1, 32'h610, HALT, 1'b0, '0, '0, 1'b0);
        step();
        idle(1'b0);
        check("rd_cause", {30'd0, cause}, 32'd1);
        check("rd_valid", {31'd0, t_valid}, 32'd1);
        rst = 1'b1;
        #1;
        check_reset_state("midreset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        check("rd_run_cycles", cycles, 32'd1);
        check("rd_run_done", {31'd0, done}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
